mismatch_scoreboard: RTL and testbench
======================================

// Module: mismatch_scoreboard
// PURPOSE
//   Sequential checker downstream of a DUT/golden-model pair. Each valid cycle
//   it compares the DUT output word against the golden output word, pulses a
//   per-sample mismatch flag and counts samples and mismatches. It records the
//   index of the first failing sample and, after NUM_SAMPLES accepted samples,
//   raises done with a pass/fail verdict.
// PARAMETERS
//   WIDTH        1   bit width of the compared output words
//   NUM_SAMPLES  10  samples per run; legal range 1 .. 2**CNT_W-1
//   CNT_W        16  width of sample_count, mismatch_count and first_fail_idx
// PORTS
//   clk               in   1      single clock; all state updates on rising edge
//   rst               in   1      asynchronous, active-high reset
//   start             in   1      begin or restart a run (1-cycle pulse)
//   sample_valid      in   1      y_val/r_val hold a sample this cycle
//   y_val             in   WIDTH  DUT output
//   r_val             in   WIDTH  golden/reference-model output
//   busy              out  1      high while state==RUN
//   mismatch          out  1      registered per-sample mismatch pulse
//   sample_count      out  CNT_W  samples accepted this run
//   mismatch_count    out  CNT_W  mismatching samples; saturates at 2**CNT_W-1
//   first_fail_valid  out  1      first_fail_idx holds a valid index
//   first_fail_idx    out  CNT_W  0-based index of first mismatching sample
//   done              out  1      run complete; held until restart or reset
//   pass              out  1      run completed with zero mismatches; valid when done=1
// BEHAVIOUR
// - rst=1, asynchronous: state=IDLE; all outputs and counters 0. Reset mid-run
//   discards the run with no verdict.
// - FSM states IDLE, RUN, DONE.
//   IDLE: start=1 -> RUN; counters, first_fail_* and mismatch are cleared.
//     sample_valid is ignored.
//   RUN: start=1 -> restart. Clear as for IDLE, stay in RUN, and discard any
//     sample presented in the same cycle.
//     Otherwise, on sample_valid=1:
//       - mis = (y_val !== r_val), case-inequality over all WIDTH bits, so an
//         X/Z on either side counts as a mismatch.
//       - sample_count += 1.
//       - If mis: mismatch_count += 1, saturating.
//       - If mis and first_fail_valid=0: first_fail_idx <= sample_count
//         (pre-increment value) and first_fail_valid <= 1.
//       - If the accepted sample is number NUM_SAMPLES (pre-increment
//         sample_count == NUM_SAMPLES-1): next state DONE, done <= 1, and
//         pass <= (updated mismatch_count == 0).
//   DONE: done and pass hold; sample_valid is ignored; start=1 -> RUN, cleared.
// - mismatch: registered with 1-cycle latency. It is high exactly in the cycle
//   after an accepted mismatching sample and 0 in every other cycle, including
//   after ignored samples.
// - Counters update in the same edge that accepts a sample. done and pass rise
//   in the edge that accepts the final sample.
// - busy = (state == RUN); it falls in the same edge that done rises.
// - Simultaneous start and sample_valid: start wins in every state.
// TESTING
// 1. 10 matching samples (y=r=1), NUM_SAMPLES=10 -> done=1 and pass=1 after the
//    10th accepted edge; mismatch_count=0, first_fail_valid=0, mismatch never 1.
// 2. Mismatches at indices 2 and 7 -> mismatch pulses one cycle after those
//    samples; final mismatch_count=2, first_fail_idx=2, pass=0.
// 3. sample_valid high every other cycle -> sample_count counts only valid
//    cycles; done rises after the 10th valid sample (about 20 cycles).
// 4. CNT_W=2, NUM_SAMPLES=3, every sample mismatching -> mismatch_count=3
//    (saturated), done=1, pass=0.
// 5. rst pulse after 4 samples, mid-cycle -> all outputs 0 immediately and state
//    IDLE; samples are ignored until start.
// 6. start in DONE and in mid-RUN; y_val=1'bx vs r_val=0 -> counters cleared and
//    run restarted (sample in the start cycle not counted); the X sample counts
//    as a mismatch.

Source files
------------

// File: rtl/mismatch_scoreboard.sv
// mismatch_scoreboard
//   Sequential checker sitting behind a DUT/golden-model pair. On each valid
//   cycle it compares the DUT word against the golden word. It pulses a
//   registered per-sample mismatch flag and counts samples and mismatches. It
//   also records the index of the first failing sample. After NUM_SAMPLES
//   accepted samples it raises done, together with a pass/fail verdict.
//
// Ports
//   clk               in   clock; all state changes on the rising edge
//   rst               in   asynchronous active-high reset
//   start             in   begin/restart a run (one-cycle pulse)
//   sample_valid      in   y_val/r_val carry a sample this cycle
//   y_val             in   DUT output word
//   r_val             in   golden/reference output word
//   busy              out  run in progress
//   mismatch          out  one-cycle pulse after an accepted mismatching sample
//   sample_count      out  samples accepted this run
//   mismatch_count    out  mismatching samples (saturating)
//   first_fail_valid  out  first_fail_idx is meaningful
//   first_fail_idx    out  0-based index of the first mismatching sample
//   done              out  run complete; held until restart or reset
//   pass              out  completed run had zero mismatches (valid when done)
module mismatch_scoreboard #(
  parameter int WIDTH       = 1,
  parameter int NUM_SAMPLES = 10,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] y_val,
  input  logic [WIDTH-1:0] r_val,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             done,
  output logic             pass
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  logic [1:0]       r_state;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_sample_count;
  logic [CNT_W-1:0] r_mismatch_count;
  logic             r_ff_valid;
  logic [CNT_W-1:0] r_ff_idx;
  logic             r_done;
  logic             r_pass;

  logic             w_mis;
  logic [CNT_W-1:0] w_mc_next;

  // Case inequality: any X/Z on either side counts as a mismatch.
  assign w_mis = (y_val !== r_val);

  always_comb begin
    w_mc_next = r_mismatch_count;
    if (w_mis && (r_mismatch_count != '1)) begin
      w_mc_next = r_mismatch_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_mismatch       <= 1'b0;
      r_sample_count   <= '0;
      r_mismatch_count <= '0;
      r_ff_valid       <= 1'b0;
      r_ff_idx         <= '0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if (start) begin
        // start wins in every state; any sample in this cycle is dropped
        r_state          <= S_RUN;
        r_sample_count   <= '0;
        r_mismatch_count <= '0;
        r_ff_valid       <= 1'b0;
        r_ff_idx         <= '0;
        r_done           <= 1'b0;
        r_pass           <= 1'b0;
      end else if ((r_state == S_RUN) && sample_valid) begin
        r_sample_count   <= r_sample_count + 1'b1;
        r_mismatch_count <= w_mc_next;
        r_mismatch       <= w_mis;
        if (w_mis && !r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_idx   <= r_sample_count;
        end
        if (r_sample_count == LAST_IDX) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_pass  <= (w_mc_next == '0);
        end
      end
    end
  end

  assign busy             = (r_state == S_RUN);
  assign mismatch         = r_mismatch;
  assign sample_count     = r_sample_count;
  assign mismatch_count   = r_mismatch_count;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_idx   = r_ff_idx;
  assign done             = r_done;
  assign pass             = r_pass;

endmodule

// File: tb/tb_mismatch_scoreboard.sv
module tb_mismatch_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sample_valid = 1'b0;
  logic y_val = 1'b0;
  logic r_val = 1'b0;

  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        busy1, mis1, ffv1, done1, pass1;
  logic [15:0] sc1, mc1, ffi1;
  // DUT B: tiny counters to exercise saturation
  logic        busy2, mis2, ffv2, done2, pass2;
  logic [1:0]  sc2, mc2, ffi2;

  mismatch_scoreboard #(.WIDTH(1), .NUM_SAMPLES(10), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .y_val(y_val), .r_val(r_val), .busy(busy1), .mismatch(mis1),
    .sample_count(sc1), .mismatch_count(mc1), .first_fail_valid(ffv1),
    .first_fail_idx(ffi1), .done(done1), .pass(pass1));

  mismatch_scoreboard #(.WIDTH(1), .NUM_SAMPLES(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .y_val(y_val), .r_val(r_val), .busy(busy2), .mismatch(mis2),
    .sample_count(sc2), .mismatch_count(mc2), .first_fail_valid(ffv2),
    .first_fail_idx(ffi2), .done(done2), .pass(pass2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit run;
    bit mis;
    bit done;
    bit pass;
    bit ffv;
    int cnt;
    int mc;
    int ffi;
  } mstate_t;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.run = 0; s.mis = 0; s.done = 0; s.pass = 0; s.ffv = 0;
    s.cnt = 0; s.mc = 0; s.ffi = 0;
    return s;
  endfunction

  function automatic mstate_t m_step(input mstate_t s, input bit st, input bit sv,
                                     input bit mis, input int num, input int cmax);
    mstate_t n = s;
    n.mis = 0;
    if (st) begin
      n = m_reset();
      n.run = 1;
    end else if (s.run && sv) begin
      n.cnt = s.cnt + 1;
      if (mis) begin
        n.mis = 1;
        n.mc  = (s.mc < cmax) ? s.mc + 1 : cmax;
        if (!s.ffv) begin
          n.ffv = 1;
          n.ffi = s.cnt;
        end
      end
      if (n.cnt == num) begin
        n.run  = 0;
        n.done = 1;
        n.pass = (n.mc == 0);
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] m_pack(input mstate_t s, input int w);
    logic [63:0] v;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    v = {59'd0, s.run, s.mis, s.done, s.pass, s.ffv};
    v = (v << w) | (64'(s.cnt) & mask);
    v = (v << w) | (64'(s.mc) & mask);
    v = (v << w) | (64'(s.ffi) & mask);
    return v;
  endfunction

  mstate_t m1 = m_reset();
  mstate_t m2 = m_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= m_reset();
      m2 <= m_reset();
    end else begin
      m1 <= m_step(m1, start, sample_valid, (y_val !== r_val), 10, 65535);
      m2 <= m_step(m2, start, sample_valid, (y_val !== r_val), 3, 3);
    end
  end

  // per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("cycle_dut1", {11'd0, busy1, mis1, done1, pass1, ffv1, sc1, mc1, ffi1}, m_pack(m1, 16));
    chk("cycle_dut2", {53'd0, busy2, mis2, done2, pass2, ffv2, sc2, mc2, ffi2}, m_pack(m2, 2));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit st, input bit v, input logic y, input logic r);
    @(negedge clk);
    start = st;
    sample_valid = v;
    y_val = y;
    r_val = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    #12;
    chk("reset_state", {busy1, mis1, done1, pass1, ffv1, sc1, mc1, ffi1}, 53'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // 1: ten matching samples
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1);
    idle(1);
    chk("t1_verdict", {done1, pass1, busy1, ffv1, mc1, sc1}, {4'b1100, 16'd0, 16'd10});
    chk("t1_dut2_done", {done2, pass2, sc2}, {2'b11, 2'd3});

    // 2: mismatches at indices 2 and 7
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 7) begin
        cyc(0, 1, 1, 0);
        @(posedge clk); #2;
        chk("t2_pulse", {31'd0, mis1}, 32'd1);
      end else begin
        cyc(0, 1, 0, 0);
      end
    end
    idle(1);
    chk("t2_verdict", {done1, pass1, ffv1, mc1, ffi1}, {3'b101, 16'd2, 16'd2});
    chk("t2_no_pulse", {31'd0, mis1}, 32'd0);

    // 3: valid every other cycle
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 19; i++) cyc(0, (i % 2 == 0), 1, 1);
    @(posedge clk); #2;
    chk("t3_done_at_10th", {done1, busy1, sc1}, {2'b10, 16'd10});
    idle(1);

    // 4: every sample mismatching -> dut2 saturates
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
    idle(1);
    chk("t4_saturate", {done2, pass2, mc2, ffi2}, {2'b10, 2'd3, 2'd0});
    chk("t4_dut1_partial", {done1, busy1, mc1}, {2'b01, 16'd3});

    // 5: asynchronous reset after four samples
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t5_async_clear", {busy1, mis1, done1, pass1, ffv1, sc1, mc1, ffi1}, 53'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
    idle(1);
    chk("t5_ignored", {busy1, sc1, mc1}, 33'd0);

    // 6: restart mid-run, X sample, restart from DONE
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1);
    cyc(1, 1, 1, 0);
    @(posedge clk); #2;
    chk("t6_restart", {busy1, mis1, sc1, mc1}, {2'b10, 16'd0, 16'd0});
    cyc(0, 1, 1'bx, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0);
    idle(1);
    chk("t6_done", {done1, sc1}, {1'b1, 16'd10});
    cyc(1, 1, 1, 0);
    @(posedge clk); #2;
    chk("t6_restart_done", {busy1, done1, pass1, mis1, sc1}, {4'b1000, 16'd0});
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
